// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, two write ports, scoreboard mark and status.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_sel;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_pending;
    logic                wr0_en;
    logic [AW-1:0]       wr0_sel;
    logic [XLEN-1:0]     wr0_data;
    logic                wr1_en;
    logic [AW-1:0]       wr1_sel;
    logic [XLEN-1:0]     wr1_data;
    logic                mark_en;
    logic [AW-1:0]       mark_sel;
    logic                any_pending;

    modport master (
        output rd_sel, wr0_en, wr0_sel, wr0_data, wr1_en, wr1_sel, wr1_data,
               mark_en, mark_sel,
        input  rd_data, rd_pending, any_pending
    );

    modport slave (
        input  rd_sel, wr0_en, wr0_sel, wr0_data, wr1_en, wr1_sel, wr1_data,
               mark_en, mark_sel,
        output rd_data, rd_pending, any_pending
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (wr1 wins on collision), NRD registered
// read ports with optional write bypass, optional hardwired zero register and a
// per-register pending scoreboard for hazard detection.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]     regs      [NREGS];
    logic [XLEN-1:0]     regs_next [NREGS];
    logic [NREGS-1:0]    pending;
    logic [NREGS-1:0]    pending_next;
    logic [AW-1:0]       rd_addr   [NRD];
    logic [NRD*XLEN-1:0] rd_data_next;
    logic [NRD-1:0]      rd_pending_next;

    // Next register contents and pending bits: wr1 applied after wr0, mark applied last.
    always_comb begin
        pending_next = pending;
        for (int unsigned i = 0; i < NREGS; i++) begin
            regs_next[i] = regs[i];
            if (!(ZERO_REG != 0 && i == 0)) begin
                if (bus.wr0_en && bus.wr0_sel == AW'(i)) begin
                    regs_next[i]    = bus.wr0_data;
                    pending_next[i] = 1'b0;
                end
                if (bus.wr1_en && bus.wr1_sel == AW'(i)) begin
                    regs_next[i]    = bus.wr1_data;
                    pending_next[i] = 1'b0;
                end
                if (bus.mark_en && bus.mark_sel == AW'(i)) begin
                    pending_next[i] = 1'b1;
                end
            end
        end
    end

    // Split the packed read-address bus into per-port addresses.
    always_comb begin
        for (int unsigned k = 0; k < NRD; k++) begin
            rd_addr[k] = bus.rd_sel[k*AW +: AW];
        end
    end

    // Read data selection; pending flags always reflect the post-edge scoreboard.
    always_comb begin
        rd_data_next    = '0;
        rd_pending_next = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            if (ZERO_REG != 0 && rd_addr[k] == '0) begin
                rd_data_next[k*XLEN +: XLEN] = '0;
            end else if (BYPASS != 0) begin
                rd_data_next[k*XLEN +: XLEN] = regs_next[rd_addr[k]];
            end else begin
                rd_data_next[k*XLEN +: XLEN] = regs[rd_addr[k]];
            end
            rd_pending_next[k] = pending_next[rd_addr[k]];
        end
    end

    // State and registered outputs; synchronous reset overrides writes and marks.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pending         <= '0;
            bus.rd_data     <= '0;
            bus.rd_pending  <= '0;
            bus.any_pending <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= regs_next[i];
            end
            pending         <= pending_next;
            bus.rd_data     <= rd_data_next;
            bus.rd_pending  <= rd_pending_next;
            bus.any_pending <= |pending_next;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, randomized traffic
// against a behavioural model (two parameter variants), and a wide 3-port sequence.
module tb_regfile_mp;
    logic clock;
    logic reset_n;

    int n_checks = 0;
    int n_errors = 0;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_a ();
    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_b ();
    regfile_mp_if #(.XLEN(64), .NREGS(16), .NRD(3)) bus_c ();

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1), .ZERO_REG(1))
        dut_a (.clock(clock), .reset_n(reset_n), .bus(bus_a));
    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0), .ZERO_REG(0))
        dut_b (.clock(clock), .reset_n(reset_n), .bus(bus_b));
    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .BYPASS(1), .ZERO_REG(1))
        dut_c (.clock(clock), .reset_n(reset_n), .bus(bus_c));

    // Variant B sees exactly the same stimulus as variant A.
    assign bus_b.rd_sel   = bus_a.rd_sel;
    assign bus_b.wr0_en   = bus_a.wr0_en;
    assign bus_b.wr0_sel  = bus_a.wr0_sel;
    assign bus_b.wr0_data = bus_a.wr0_data;
    assign bus_b.wr1_en   = bus_a.wr1_en;
    assign bus_b.wr1_sel  = bus_a.wr1_sel;
    assign bus_b.wr1_data = bus_a.wr1_data;
    assign bus_b.mark_en  = bus_a.mark_en;
    assign bus_b.mark_sel = bus_a.mark_sel;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n;
        logic        w0_en;
        logic [4:0]  w0_sel;
        logic [31:0] w0_data;
        logic        w1_en;
        logic [4:0]  w1_sel;
        logic [31:0] w1_data;
        logic        m_en;
        logic [4:0]  m_sel;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic        ep0;
        logic        ep1;
        logic        eany;
    } vec_t;

    vec_t tbl [16];

    // Reference model state: index 0 = BYPASS=1/ZERO_REG=1, index 1 = BYPASS=0/ZERO_REG=0.
    logic [31:0] m_regs [2][32];
    logic [31:0] m_pend [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        reset_n        = v.rst_n;
        bus_a.wr0_en   = v.w0_en;
        bus_a.wr0_sel  = v.w0_sel;
        bus_a.wr0_data = v.w0_data;
        bus_a.wr1_en   = v.w1_en;
        bus_a.wr1_sel  = v.w1_sel;
        bus_a.wr1_data = v.w1_data;
        bus_a.mark_en  = v.m_en;
        bus_a.mark_sel = v.m_sel;
        bus_a.rd_sel   = {v.rs1, v.rs0};
    endtask

    // Predict from the model, advance one clock, compare both 32-bit variants.
    task automatic run_cycle();
        logic [31:0] nr [32];
        logic [31:0] np;
        logic [4:0]  rs [2];
        logic [31:0] ed [2][2];
        logic        ep [2][2];
        logic        ea [2];
        logic        byp, zr;
        rs[0] = bus_a.rd_sel[4:0];
        rs[1] = bus_a.rd_sel[9:5];
        for (int v = 0; v < 2; v++) begin
            byp = (v == 0);
            zr  = (v == 0);
            if (!reset_n) begin
                for (int i = 0; i < 32; i++) m_regs[v][i] = '0;
                m_pend[v] = '0;
                for (int k = 0; k < 2; k++) begin
                    ed[v][k] = '0;
                    ep[v][k] = 1'b0;
                end
                ea[v] = 1'b0;
            end else begin
                for (int i = 0; i < 32; i++) nr[i] = m_regs[v][i];
                np = m_pend[v];
                if (bus_a.wr0_en && !(zr && bus_a.wr0_sel == 5'd0)) begin
                    nr[bus_a.wr0_sel] = bus_a.wr0_data;
                    np[bus_a.wr0_sel] = 1'b0;
                end
                if (bus_a.wr1_en && !(zr && bus_a.wr1_sel == 5'd0)) begin
                    nr[bus_a.wr1_sel] = bus_a.wr1_data;
                    np[bus_a.wr1_sel] = 1'b0;
                end
                if (bus_a.mark_en && !(zr && bus_a.mark_sel == 5'd0))
                    np[bus_a.mark_sel] = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    if (zr && rs[k] == 5'd0) ed[v][k] = '0;
                    else if (byp)            ed[v][k] = nr[rs[k]];
                    else                     ed[v][k] = m_regs[v][rs[k]];
                    ep[v][k] = np[rs[k]];
                end
                ea[v] = |np;
                for (int i = 0; i < 32; i++) m_regs[v][i] = nr[i];
                m_pend[v] = np;
            end
        end
        @(posedge clock);
        #1;
        chk("model_a_d0", 64'(bus_a.rd_data[31:0]),  64'(ed[0][0]));
        chk("model_a_d1", 64'(bus_a.rd_data[63:32]), 64'(ed[0][1]));
        chk("model_a_p0", 64'(bus_a.rd_pending[0]),  64'(ep[0][0]));
        chk("model_a_p1", 64'(bus_a.rd_pending[1]),  64'(ep[0][1]));
        chk("model_a_any", 64'(bus_a.any_pending),   64'(ea[0]));
        chk("model_b_d0", 64'(bus_b.rd_data[31:0]),  64'(ed[1][0]));
        chk("model_b_d1", 64'(bus_b.rd_data[63:32]), 64'(ed[1][1]));
        chk("model_b_p0", 64'(bus_b.rd_pending[0]),  64'(ep[1][0]));
        chk("model_b_p1", 64'(bus_b.rd_pending[1]),  64'(ep[1][1]));
        chk("model_b_any", 64'(bus_b.any_pending),   64'(ea[1]));
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        reset_n = 1'b0;
        bus_a.rd_sel = '0;
        bus_a.wr0_en = 1'b0; bus_a.wr0_sel = '0; bus_a.wr0_data = '0;
        bus_a.wr1_en = 1'b0; bus_a.wr1_sel = '0; bus_a.wr1_data = '0;
        bus_a.mark_en = 1'b0; bus_a.mark_sel = '0;
        bus_c.rd_sel = '0;
        bus_c.wr0_en = 1'b0; bus_c.wr0_sel = '0; bus_c.wr0_data = '0;
        bus_c.wr1_en = 1'b0; bus_c.wr1_sel = '0; bus_c.wr1_data = '0;
        bus_c.mark_en = 1'b0; bus_c.mark_sel = '0;

        // rst, w0(en,sel,data), w1(en,sel,data), mark(en,sel), rs0, rs1, exp d0, d1, p0, p1, any (variant A)
        tbl[0]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 5'd6,  32'h1,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd6,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd6,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 5'd3,  32'h12345678, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd5,  32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 5'd7,  32'hAAAA0000, 1'b1, 5'd7,  32'h5555FFFF, 1'b0, 5'd0,  5'd7,  5'd7,  32'h5555FFFF, 32'h5555FFFF, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 5'd8,  32'h1,        1'b1, 5'd9,  32'h2,        1'b0, 5'd0,  5'd8,  5'd9,  32'h1,        32'h2,        1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd8,  32'h5555FFFF, 32'h1,        1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd9,  32'h0,        32'h2,        1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 5'd10, 5'd3,  32'h0,        32'h12345678, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 5'd10, 32'h42,       1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 5'd10, 5'd10, 32'h42,       32'h42,       1'b1, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h43,       1'b0, 5'd0,  5'd10, 5'd0,  32'h43,       32'h0,        1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 5'd12, 5'd10, 32'h0,        32'h43,       1'b1, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 5'd12, 32'h7,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd12, 32'h7,        32'h7,        1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            apply_vec(tbl[i]);
            run_cycle();
            chk($sformatf("tbl%0d_d0", i),  64'(bus_a.rd_data[31:0]),  64'(tbl[i].ed0));
            chk($sformatf("tbl%0d_d1", i),  64'(bus_a.rd_data[63:32]), 64'(tbl[i].ed1));
            chk($sformatf("tbl%0d_p0", i),  64'(bus_a.rd_pending[0]),  64'(tbl[i].ep0));
            chk($sformatf("tbl%0d_p1", i),  64'(bus_a.rd_pending[1]),  64'(tbl[i].ep1));
            chk($sformatf("tbl%0d_any", i), 64'(bus_a.any_pending),    64'(tbl[i].eany));
            // Without zero register and bypass, reg 0 keeps the value written in vector 9.
            if (i == 10) chk("b_reg0_ordinary", 64'(bus_b.rd_data[31:0]), 64'h0000_0000_FFFF_FFFF);
        end

        // Randomized traffic with occasional resets, checked against the model.
        for (int n = 0; n < 1500; n++) begin
            reset_n        = ($urandom_range(0, 63) != 0);
            bus_a.wr0_en   = 1'($urandom_range(0, 1));
            bus_a.wr0_sel  = rnd_addr();
            bus_a.wr0_data = $urandom;
            bus_a.wr1_en   = 1'($urandom_range(0, 1));
            bus_a.wr1_sel  = rnd_addr();
            bus_a.wr1_data = $urandom;
            bus_a.mark_en  = ($urandom_range(0, 3) == 0);
            bus_a.mark_sel = rnd_addr();
            bus_a.rd_sel   = {rnd_addr(), rnd_addr()};
            run_cycle();
        end

        // Wide three-port configuration: concurrent distinct reads, 64-bit round trip.
        reset_n = 1'b1;
        bus_a.wr0_en = 1'b0; bus_a.wr1_en = 1'b0; bus_a.mark_en = 1'b0;
        bus_c.wr0_en = 1'b1; bus_c.wr0_sel = 4'd1; bus_c.wr0_data = 64'h0123456789ABCDEF;
        bus_c.wr1_en = 1'b1; bus_c.wr1_sel = 4'd2; bus_c.wr1_data = 64'hFEDCBA9876543210;
        @(posedge clock); #1;
        bus_c.wr0_sel = 4'd15; bus_c.wr0_data = 64'hA5A5A5A55A5A5A5A;
        bus_c.wr1_en  = 1'b0;
        bus_c.rd_sel  = {4'd15, 4'd2, 4'd1};
        @(posedge clock); #1;
        chk("c_p0_reg1",  bus_c.rd_data[63:0],    64'h0123456789ABCDEF);
        chk("c_p1_reg2",  bus_c.rd_data[127:64],  64'hFEDCBA9876543210);
        chk("c_p2_byp15", bus_c.rd_data[191:128], 64'hA5A5A5A55A5A5A5A);
        bus_c.wr0_en = 1'b0;
        bus_c.rd_sel = {4'd2, 4'd1, 4'd15};
        @(posedge clock); #1;
        chk("c_p0_reg15", bus_c.rd_data[63:0],    64'hA5A5A5A55A5A5A5A);
        chk("c_p1_reg1",  bus_c.rd_data[127:64],  64'h0123456789ABCDEF);
        chk("c_p2_reg2",  bus_c.rd_data[191:128], 64'hFEDCBA9876543210);
        chk("c_pending",  64'(bus_c.rd_pending),  64'h0);
        chk("c_any",      64'(bus_c.any_pending), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
